// File: rtl/bus_turn_arbiter.sv
// bus_turn_arbiter
//   Round-robin arbiter and sequencer for the shared bidirectional DataB bus.
//   One requester owns the bus at a time. Each tenure runs GRANT (setup),
//   HOLD (driving) and TURN (released), so two drivers never overlap. A hold
//   counter bounds each tenure and forces release after MaxHold cycles.
//
// Parameters
//   NReq    number of requesters (2..8)
//   OwnerW  width of BusOwner, at least ceil(log2(NReq))
//   MaxHold maximum HOLD cycles before forced release (1..255)
//
// Ports
//   Clk      rising-edge clock
//   Reset    synchronous, active-high reset
//   Req      per-requester level request, held until Done
//   Done     per-requester end-of-transfer strobe; only the owner's bit counts
//   Grant    one-hot grant, zero when there is no owner
//   DriveEn  owner may drive DataB (HOLD only)
//   Ctl      bus-block control mask, all ones while DriveEn is high
//   BusOwner index of the granted requester, zero when Grant is zero
//   Busy     high in GRANT, HOLD and TURN
//   Timeout  one-cycle pulse when a tenure is force-released
//
// All outputs come straight from flops.
module bus_turn_arbiter #(
   parameter int NReq    = 4,
   parameter int OwnerW  = 2,
   parameter int MaxHold = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [NReq-1:0]   Req,
   input  logic [NReq-1:0]   Done,
   output logic [NReq-1:0]   Grant,
   output logic              DriveEn,
   output logic [3:0]        Ctl,
   output logic [OwnerW-1:0] BusOwner,
   output logic              Busy,
   output logic              Timeout
);

   localparam logic [OwnerW-1:0] LAST_IDX = OwnerW'(NReq - 1);
   localparam logic [7:0]        MAX_HOLD = 8'(MaxHold);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_HOLD  = 2'd2,
      S_TURN  = 2'd3
   } state_t;

   // Index increment with wrap at NReq (NReq need not be a power of two).
   function automatic logic [OwnerW-1:0] wrap_inc(input logic [OwnerW-1:0] i);
      return (i == LAST_IDX) ? '0 : i + OwnerW'(1);
   endfunction

   state_t            state_q,    state_d;
   logic [OwnerW-1:0] ptr_q,      ptr_d;
   logic [NReq-1:0]   grant_q,    grant_d;
   logic [OwnerW-1:0] owner_q,    owner_d;
   logic              drive_en_q, drive_en_d;
   logic [3:0]        ctl_q,      ctl_d;
   logic              busy_q,     busy_d;
   logic              timeout_q,  timeout_d;
   logic [7:0]        hold_cnt_q, hold_cnt_d;

   logic [OwnerW-1:0] win;
   logic [OwnerW-1:0] scan_idx;
   logic              found;
   logic              owner_req;
   logic              owner_done;

   // Round-robin winner: first set Req bit scanning from ptr_q upward with wrap.
   always_comb begin
      win      = ptr_q;
      found    = 1'b0;
      scan_idx = ptr_q;
      for (int i = 0; i < NReq; i++) begin
         if (!found && Req[scan_idx]) begin
            win   = scan_idx;
            found = 1'b1;
         end
         scan_idx = wrap_inc(scan_idx);
      end
   end

   // owner_q holds W throughout GRANT and HOLD, so it selects the owner's bits.
   assign owner_req  = Req[owner_q];
   assign owner_done = Done[owner_q];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      drive_en_d = drive_en_q;
      busy_d     = busy_q;
      timeout_d  = 1'b0;
      hold_cnt_d = hold_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            grant_d    = '0;
            owner_d    = '0;
            drive_en_d = 1'b0;
            busy_d     = 1'b0;
            if (found) begin
               state_d = S_GRANT;
               grant_d = NReq'(1) << win;
               owner_d = win;
               busy_d  = 1'b1;
               ptr_d   = wrap_inc(win);
            end
         end

         S_GRANT: begin
            if (owner_req) begin
               state_d    = S_HOLD;
               drive_en_d = 1'b1;
               hold_cnt_d = 8'd1;
            end else begin
               // Requester withdrew before driving: release without a tenure.
               state_d = S_TURN;
               grant_d = '0;
               owner_d = '0;
            end
         end

         S_HOLD: begin
            // Done/withdraw has priority, so a coincident timeout is not flagged.
            if (owner_done || !owner_req) begin
               state_d    = S_TURN;
               grant_d    = '0;
               owner_d    = '0;
               drive_en_d = 1'b0;
            end else if (hold_cnt_q == MAX_HOLD) begin
               state_d    = S_TURN;
               grant_d    = '0;
               owner_d    = '0;
               drive_en_d = 1'b0;
               timeout_d  = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end

         S_TURN: begin
            state_d    = S_IDLE;
            grant_d    = '0;
            owner_d    = '0;
            drive_en_d = 1'b0;
            busy_d     = 1'b0;
            hold_cnt_d = 8'd0;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      ctl_d = {4{drive_en_d}};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         grant_q    <= '0;
         owner_q    <= '0;
         drive_en_q <= 1'b0;
         ctl_q      <= 4'b0000;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         hold_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         drive_en_q <= drive_en_d;
         ctl_q      <= ctl_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign Grant    = grant_q;
   assign DriveEn  = drive_en_q;
   assign Ctl      = ctl_q;
   assign BusOwner = owner_q;
   assign Busy     = busy_q;
   assign Timeout  = timeout_q;

endmodule

// File: tb/tb_bus_turn_arbiter.sv
// Testbench for bus_turn_arbiter (NReq=4, OwnerW=2, MaxHold=8).
// Each vector gives the inputs applied before a rising edge and the outputs
// required just after it.
module tb_bus_turn_arbiter;

   logic       Clk;
   logic       Reset;
   logic [3:0] Req;
   logic [3:0] Done;
   logic [3:0] Grant;
   logic       DriveEn;
   logic [3:0] Ctl;
   logic [1:0] BusOwner;
   logic       Busy;
   logic       Timeout;

   int checks = 0;
   int errors = 0;
   bit inv_en = 1'b0;

   bus_turn_arbiter #(
      .NReq   (4),
      .OwnerW (2),
      .MaxHold(8)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Req     (Req),
      .Done    (Done),
      .Grant   (Grant),
      .DriveEn (DriveEn),
      .Ctl     (Ctl),
      .BusOwner(BusOwner),
      .Busy    (Busy),
      .Timeout (Timeout)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       rst;
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] grant;
      logic [1:0] own;
      logic       drv;
      logic       busy;
      logic       tmo;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   function automatic vec_t mk(input logic rst, input logic [3:0] req,
                               input logic [3:0] done, input logic [3:0] grant,
                               input logic [1:0] own, input logic drv,
                               input logic busy, input logic tmo);
      vec_t v;
      v.rst = rst; v.req = req; v.done = done; v.grant = grant;
      v.own = own; v.drv = drv; v.busy = busy; v.tmo = tmo;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, want);
      end
   endtask

   // Drive one vector, queue its expectation, then compare after the edge.
   task automatic step(input string tag, input vec_t v);
      vec_t e;
      @(negedge Clk);
      Reset = v.rst;
      Req   = v.req;
      Done  = v.done;
      exp_q.push_back(v);
      @(posedge Clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, " Grant"},    32'(Grant),    32'(e.grant));
         check({tag, " BusOwner"}, 32'(BusOwner), 32'(e.own));
         check({tag, " DriveEn"},  32'(DriveEn),  32'(e.drv));
         check({tag, " Ctl"},      32'(Ctl),      32'({4{e.drv}}));
         check({tag, " Busy"},     32'(Busy),     32'(e.busy));
         check({tag, " Timeout"},  32'(Timeout),  32'(e.tmo));
      end
   endtask

   // Structural invariants, sampled away from the active edge.
   always @(negedge Clk) begin
      if (inv_en) begin
         check("inv grant onehot0", 32'($onehot0(Grant)), 32'd1);
         check("inv drive implies grant", 32'(!DriveEn || (Grant != 4'b0000)), 32'd1);
         check("inv ctl mirrors drive", 32'(Ctl), 32'({4{DriveEn}}));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b0;
      Req   = 4'b0000;
      Done  = 4'b0000;

      //           rst  req      done     grant    own   drv   busy  tmo
      // reset
      tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
      // single requester 2, Done after two HOLD cycles
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
      // owner 2 into HOLD, then reset mid-HOLD (Ptr was 3)
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
      // Ptr restarted at 0: requester 0 beats requester 3
      tbl.push_back(mk(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0));
      // owner 0 withdraws in HOLD; requester 3 waits through TURN
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0));
      // abort: owner 3 drops Req during GRANT
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
      // foreign Done bits ignored while owner is 3
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b1000, 4'b0001, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b1000, 4'b0111, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
      // Done on the 8th HOLD cycle wins over the timeout
      tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i]);
         inv_en = 1'b1;
      end

      // Timeout: requester 1 never signals Done; 8 DriveEn cycles, then pulse.
      step("tmo grant", mk(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < 8; i++)
         step($sformatf("tmo hold%0d", i + 1),
              mk(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0));
      step("tmo release", mk(0, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1));
      step("tmo idle",    mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));

      // Fairness: all four requesting, each owner Done after two HOLD cycles.
      step("rr reset", mk(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < 5; k++) begin
         logic [1:0] w;
         logic [3:0] oh;
         w  = 2'(k % 4);
         oh = 4'b0001 << w;
         step($sformatf("rr%0d grant", k), mk(0, 4'b1111, 4'b0000, oh, w, 1'b0, 1'b1, 1'b0));
         step($sformatf("rr%0d hold1", k), mk(0, 4'b1111, 4'b0000, oh, w, 1'b1, 1'b1, 1'b0));
         step($sformatf("rr%0d hold2", k), mk(0, 4'b1111, 4'b0000, oh, w, 1'b1, 1'b1, 1'b0));
         step($sformatf("rr%0d turn", k),  mk(0, 4'b1111, oh, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
         step($sformatf("rr%0d idle", k),  mk(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
      end

      @(negedge Clk);
      inv_en = 1'b0;
      Req    = 4'b0000;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_turn_arbiter.md
Name: bus_turn_arbiter

Overview:
Round-robin arbiter and sequencer for the shared bidirectional DataB bus driven by the Level-style blocks. It grants exactly one requester at a time and enables that requester's bus driver. It enforces a one-cycle turnaround between owners so two drivers never overlap. It also bounds each tenure with a hold timeout.

Parameters:
NReq, 4, number of requesters (2..8).
OwnerW, 2, width of BusOwner; must be ≥ ceil(log2(NReq)).
MaxHold, 8, maximum cycles in HOLD before forced release (1..255).

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  synchronous, active-high reset.
Req  input  NReq  per-requester bus request; level, held until Done.
Done  input  NReq  per-requester end-of-transfer strobe; only the owner's bit is sampled.
Grant  output  NReq  one-hot grant; all-zero when no owner.
DriveEn  output  1  owner may drive DataB; high only in HOLD.
Ctl  output  4  control mask to the bus block: 4'b1111 in HOLD, 4'b0000 otherwise.
BusOwner  output  OwnerW  index of granted requester; 0 when Grant is zero.
Busy  output  1  high in GRANT, HOLD, TURN.
Timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- All outputs are registered. Reset (sync, active-high) forces the following at the next edge, from any state: state IDLE, Grant 0, DriveEn 0, Ctl 0, BusOwner 0, Busy 0, Timeout 0, round-robin pointer Ptr 0, hold counter 0.
- FSM states: IDLE, GRANT, HOLD, TURN.
- IDLE:
  - If Req is nonzero, select the winner W as the first set bit scanning Ptr, Ptr+1, … with wrap mod NReq.
  - Next edge: Grant = one-hot(W), BusOwner = W, Busy = 1, Ptr = (W+1) mod NReq, go to GRANT.
  - If Req is zero, stay in IDLE.
- GRANT (1 cycle, setup):
  - DriveEn stays 0.
  - If Req[W] is still 1: go to HOLD, DriveEn = 1, Ctl = 4'b1111, hold counter = 1.
  - If Req[W] has dropped: abort to TURN.
- HOLD:
  - Each cycle, evaluate in priority order:
    - Done[W] = 1 or Req[W] = 0: go to TURN.
    - Else if hold counter == MaxHold: go to TURN and pulse Timeout = 1 for exactly one cycle, coincident with entering TURN.
    - Else increment the hold counter.
  - If Done and the timeout condition occur in the same cycle, Done wins and Timeout stays 0.
  - Done bits of non-owners are ignored in all states.
- TURN (1 cycle, bus released):
  - Grant 0, DriveEn 0, Ctl 0, BusOwner 0, Busy 1.
  - Next edge: go to IDLE.
- Re-arbitration therefore takes one IDLE cycle after TURN. Minimum gap between one owner's DriveEn falling and the next owner's DriveEn rising is 3 cycles (TURN, IDLE, GRANT).
- Latency: a Req sampled in IDLE at edge k gives Grant at edge k+1 and DriveEn at edge k+2.
- Maximum DriveEn tenure is MaxHold cycles.
- Invariants:
  - Grant is always zero or one-hot.
  - DriveEn = 1 implies Grant is nonzero.
  - Ctl == {4{DriveEn}}.
- New requests arriving during GRANT, HOLD or TURN are not lost; they are evaluated in the next IDLE.

Test Plan:
- Reset mid-HOLD: owner 2 in HOLD, assert Reset for 1 cycle -> next edge all outputs 0, state IDLE; then Req=4'b0001 -> Grant=4'b0001 and Ptr effectively restarts at 0.
- Single requester: Req=4'b0100 in IDLE at edge k -> Grant=4'b0100 and BusOwner=2 at k+1, DriveEn=1 and Ctl=4'hF at k+2; Done[2] pulse -> DriveEn=0 at the next edge, Busy=0 two edges later.
- Round-robin fairness: Req=4'b1111 held, each owner pulses Done after 2 HOLD cycles -> grant order 0,1,2,3,0; DriveEn never overlaps; at least 3 low cycles between tenures.
- Timeout: Req=4'b0010, Done never asserted, MaxHold=8 -> DriveEn high exactly 8 cycles, Timeout=1 for one cycle on release, then Grant=0.
- Done and timeout coincident: Done[1] asserted on the 8th HOLD cycle -> TURN entered with Timeout=0.
- Abort and foreign Done: owner 3 drops Req during GRANT -> DriveEn never asserts, TURN follows. Done=4'b0001 while owner is 3 -> ignored, HOLD continues.
